// File: rtl/op_batch_feeder.sv
// rtl/op_batch_feeder.sv - operation FIFO and batch pacer feeding the third-largest ALU engine
module op_batch_feeder #(
    parameter int FIFO_DEPTH = 16,
    parameter int PTR_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_A,
    input  logic [7:0]       in_B,
    input  logic [3:0]       in_instr,
    input  logic             batch_go,
    input  logic [7:0]       batch_len,
    output logic             busy,
    output logic             batch_err,
    output logic [PTR_W:0]   fifo_level,
    output logic             start,
    output logic [7:0]       count,
    output logic             valid,
    output logic [7:0]       data_A,
    output logic [7:0]       data_B,
    output logic [3:0]       instruction,
    input  logic             finish,
    input  logic [7:0]       third_largest,
    output logic [7:0]       result,
    output logic             result_valid
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        GAP,
        ISSUE,
        WAIT_FIN,
        DONE
    } state_t;

    localparam logic [PTR_W:0] DEPTH_L = (PTR_W + 1)'(FIFO_DEPTH);

    logic [19:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             in_ready_q, in_ready_d;

    state_t           state_q, state_d;
    logic [7:0]       remaining_q, remaining_d;
    logic             busy_q, busy_d;
    logic             batch_err_q, batch_err_d;
    logic             start_q, start_d;
    logic [7:0]       count_q, count_d;
    logic             valid_q, valid_d;
    logic [7:0]       data_a_q, data_a_d;
    logic [7:0]       data_b_q, data_b_d;
    logic [3:0]       instr_q, instr_d;
    logic [7:0]       result_q, result_d;
    logic             result_valid_q, result_valid_d;

    logic             push;
    logic             pop;
    logic [19:0]      head;

    assign push = in_valid && in_ready_q;
    assign head = mem_q[rd_ptr_q];

    // Storage array carries no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_A, in_B, in_instr};
        end
    end

    always_comb begin
        state_d        = state_q;
        remaining_d    = remaining_q;
        busy_d         = busy_q;
        batch_err_d    = 1'b0;
        start_d        = 1'b0;
        count_d        = 8'd0;
        valid_d        = 1'b0;
        data_a_d       = 8'd0;
        data_b_d       = 8'd0;
        instr_d        = 4'd0;
        result_d       = result_q;
        result_valid_d = 1'b0;
        pop            = 1'b0;

        case (state_q)
            IDLE: begin
                if (batch_go) begin
                    if (batch_len != 8'd0) begin
                        remaining_d = batch_len;
                        start_d     = 1'b1;
                        count_d     = batch_len;
                        busy_d      = 1'b1;
                        state_d     = START;
                    end else begin
                        batch_err_d = 1'b1;
                    end
                end
            end
            START: begin
                state_d = GAP;
            end
            // Every beat passes through GAP first, so beats are at least two cycles apart.
            GAP: begin
                if (remaining_q == 8'd0) begin
                    state_d = WAIT_FIN;
                end else if (level_q != '0) begin
                    pop         = 1'b1;
                    valid_d     = 1'b1;
                    data_a_d    = head[19:12];
                    data_b_d    = head[11:4];
                    instr_d     = head[3:0];
                    remaining_d = remaining_q - 8'd1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                state_d = GAP;
            end
            WAIT_FIN: begin
                if (finish) begin
                    result_d       = third_largest;
                    result_valid_d = 1'b1;
                    state_d        = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
        in_ready_d = (level_d != DEPTH_L);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            remaining_q    <= 8'd0;
            busy_q         <= 1'b0;
            batch_err_q    <= 1'b0;
            start_q        <= 1'b0;
            count_q        <= 8'd0;
            valid_q        <= 1'b0;
            data_a_q       <= 8'd0;
            data_b_q       <= 8'd0;
            instr_q        <= 4'd0;
            result_q       <= 8'd0;
            result_valid_q <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            in_ready_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            busy_q         <= busy_d;
            batch_err_q    <= batch_err_d;
            start_q        <= start_d;
            count_q        <= count_d;
            valid_q        <= valid_d;
            data_a_q       <= data_a_d;
            data_b_q       <= data_b_d;
            instr_q        <= instr_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            in_ready_q     <= in_ready_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign fifo_level   = level_q;
    assign busy         = busy_q;
    assign batch_err    = batch_err_q;
    assign start        = start_q;
    assign count        = count_q;
    assign valid        = valid_q;
    assign data_A       = data_a_q;
    assign data_B       = data_b_q;
    assign instruction  = instr_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_op_batch_feeder.sv
// tb/tb_op_batch_feeder.sv - scoreboard bench for op_batch_feeder
module tb_op_batch_feeder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_A, in_B;
    logic [3:0] in_instr;
    logic       batch_go;
    logic [7:0] batch_len;
    logic       busy, batch_err;
    logic [4:0] fifo_level;
    logic       start;
    logic [7:0] count;
    logic       valid;
    logic [7:0] data_A, data_B;
    logic [3:0] instruction;
    logic       finish;
    logic [7:0] third_largest;
    logic [7:0] result;
    logic       result_valid;

    op_batch_feeder #(.FIFO_DEPTH(16), .PTR_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_A(in_A), .in_B(in_B), .in_instr(in_instr),
        .batch_go(batch_go), .batch_len(batch_len),
        .busy(busy), .batch_err(batch_err), .fifo_level(fifo_level),
        .start(start), .count(count), .valid(valid),
        .data_A(data_A), .data_B(data_B), .instruction(instruction),
        .finish(finish), .third_largest(third_largest),
        .result(result), .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [19:0] mfifo[$];
    int          exp_len[$];
    logic [7:0]  exp_res[$];
    bit          model_busy = 0;

    int cyc = 0;
    int start_cyc = -100;
    int last_valid = -100;
    int beat_cnt = 0;
    int cur_len = 0;
    bit prev_rv = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (start) begin
                if (exp_len.size() == 0) check("unexpected_start", 1, 0);
                else begin
                    cur_len = exp_len.pop_front();
                    check("start_count", count, cur_len);
                end
                beat_cnt  = 0;
                start_cyc = cyc;
            end
            if (valid) begin
                if (mfifo.size() == 0) check("unexpected_beat", 1, 0);
                else check("beat_data", {data_A, data_B, instruction}, mfifo.pop_front());
                check("beat_after_start", (cyc - start_cyc) >= 2, 1);
                check("beat_spacing", (cyc - last_valid) >= 2, 1);
                last_valid = cyc;
                beat_cnt++;
            end
            if (result_valid) begin
                if (exp_res.size() == 0) check("unexpected_result", 1, 0);
                else check("result", result, exp_res.pop_front());
                check("beats_in_batch", beat_cnt, cur_len);
                check("result_valid_width", prev_rv, 0);
            end
            prev_rv = result_valid;
        end
    end

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] i, input bit chk);
        @(negedge clk);
        in_valid = 1; in_A = a; in_B = b; in_instr = i;
        if (chk) check("in_ready", in_ready, mfifo.size() < 16);
        if (mfifo.size() < 16) mfifo.push_back({a, b, i});
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic go(input logic [7:0] len);
        @(negedge clk);
        batch_go = 1; batch_len = len;
        if (!model_busy && len != 0) begin
            exp_len.push_back(len);
            model_busy = 1;
        end
        @(negedge clk);
        batch_go = 0; batch_len = 0;
    endtask

    task automatic fin(input logic [7:0] v);
        int n = 0;
        @(negedge clk);
        while (beat_cnt != cur_len && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("beats_timeout", n < 400, 1);
        @(negedge clk);
        @(negedge clk);
        finish = 1; third_largest = v;
        exp_res.push_back(v);
        @(negedge clk);
        finish = 0; third_largest = 0;
        @(negedge clk);
        check("busy_after_done", busy, 0);
        model_busy = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 0; in_valid = 0; in_A = 0; in_B = 0; in_instr = 0;
        batch_go = 0; batch_len = 0; finish = 0; third_largest = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_level", fifo_level, 0);
        check("rst_busy", busy, 0);
        check("rst_start", start, 0);
        check("rst_valid", valid, 0);
        check("rst_result", result, 0);
        check("rst_result_valid", result_valid, 0);

        // basic three-op batch
        push(8'h10, 8'h20, 4'h1, 1);
        push(8'h30, 8'h40, 4'h2, 1);
        push(8'h50, 8'h60, 4'h3, 1);
        go(3);
        fin(8'h11);

        // fill, drop 17th, drain
        for (int k = 0; k < 17; k++) push(8'(k), 8'(8'hF0 - k), 4'(k), 1);
        check("full_level", fifo_level, 16);
        check("full_in_ready", in_ready, 0);
        go(16);
        fin(8'h22);
        check("drained_level", fifo_level, 0);
        check("drained_in_ready", in_ready, 1);

        // starvation, spurious finish and busy go ignored
        push(8'hA1, 8'hB1, 4'h4, 0);
        push(8'hA2, 8'hB2, 4'h5, 0);
        go(5);
        repeat (20) @(negedge clk);
        check("starve_busy", busy, 1);
        check("starve_beats", beat_cnt, 2);
        finish = 1; third_largest = 8'hEE;
        @(negedge clk);
        finish = 0; third_largest = 0;
        go(4);
        check("busy_go_no_err", batch_err, 0);
        push(8'hA3, 8'hB3, 4'h6, 0);
        push(8'hA4, 8'hB4, 4'h7, 0);
        push(8'hA5, 8'hB5, 4'h8, 0);
        check("refill_busy", busy, 1);
        fin(8'h77);

        // zero-length batch
        go(0);
        check("err_pulse", batch_err, 1);
        check("err_busy", busy, 0);
        @(negedge clk);
        check("err_cleared", batch_err, 0);
        check("err_no_busy", busy, 0);

        // result capture and hold
        push(8'h01, 8'h02, 4'h9, 0);
        go(1);
        fin(8'h5A);
        check("result_hold0", result, 8'h5A);
        check("result_valid_low", result_valid, 0);
        repeat (3) @(negedge clk);
        check("result_hold3", result, 8'h5A);

        // asynchronous reset mid-batch
        push(8'hC1, 8'hD1, 4'hA, 0);
        push(8'hC2, 8'hD2, 4'hB, 0);
        push(8'hC3, 8'hD3, 4'hC, 0);
        go(3);
        n = 0;
        while (beat_cnt < 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("pre_reset_timeout", n < 100, 1);
        #3 rst_n = 0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", valid, 0);
        check("arst_start", start, 0);
        check("arst_level", fifo_level, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_result", result, 0);
        mfifo.delete(); exp_len.delete(); exp_res.delete();
        model_busy = 0;
        @(negedge clk);
        rst_n = 1;
        push(8'hE1, 8'hF1, 4'hD, 1);
        push(8'hE2, 8'hF2, 4'hE, 1);
        go(2);
        fin(8'h33);
        check("post_reset_level", fifo_level, 0);
        check("scoreboard_empty", mfifo.size() + exp_len.size() + exp_res.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
